mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single external SRAM port between the instruction-fetch (IF) requester and the data-memory (MEM) requester.
- Sequences each SRAM access as setup, strobe and hold phases, with a parameterised strobe width.
- Sits between the pipeline memory-access logic and the SRAM pins.
- Returns a one-cycle acknowledge, plus read data, to whichever requester was granted.

Parameters:
- ADDR_W, 18, SRAM word-address width
- DATA_W, 16, SRAM data width
- WAIT_CYC, 2, number of cycles OE_n/WE_n is held low per access (legal range 1..15)

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- if_req  input  1  IF read request; level, held until if_ack
- if_addr  input  ADDR_W  IF word address
- if_ack  output  1  one-cycle pulse: IF access complete, if_rdata valid
- if_rdata  output  DATA_W  last word read for IF
- mem_rd  input  1  MEM read request; level, held until mem_ack
- mem_wr  input  1  MEM write request; level, held until mem_ack
- mem_addr  input  ADDR_W  MEM word address
- mem_wdata  input  DATA_W  MEM write data
- mem_ack  output  1  one-cycle pulse: MEM access complete, mem_rdata valid for reads
- mem_rdata  output  DATA_W  last word read for MEM
- busy  output  1  high whenever state is not IDLE
- ram_addr  output  ADDR_W  SRAM address
- ram_data  inout  DATA_W  SRAM data bus; driven only during writes, else Z
- ram_ce_n  output  1  SRAM chip enable, active low
- ram_oe_n  output  1  SRAM output enable, active low
- ram_we_n  output  1  SRAM write enable, active low

Behaviour:
- Interface: one clock, clk. Reset is rst: synchronous, active-high.
- Reset values:
  - state=IDLE; ram_ce_n/oe_n/we_n=1; ram_addr=0; ram_data=Z.
  - if_ack=mem_ack=0; if_rdata=mem_rdata=0; busy=0.
  - last_grant=IF, so MEM wins the first tie.
  - Reset mid-access abandons the access: strobes go high and the bus goes Z on the next edge, and no ack is issued.
- States: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - Sample requests.
  - If any request is pending, grant it and latch op/addr/wdata into internal registers, then go to SETUP.
  - Requester inputs are ignored from then until the ack.
- Arbitration:
  - Only one requester pending: grant it.
  - Both pending: grant the one not in last_grant (round-robin), then update last_grant to the winner.
  - This guarantees neither side waits more than one access.
- mem_rd and mem_wr both high: treated as a write.
- SETUP (1 cycle): ram_ce_n=0 and ram_addr=latched addr. For a write, ram_data is driven with the latched wdata. oe_n=we_n=1.
- STROBE (WAIT_CYC cycles, 4-bit counter):
  - Read: oe_n=0.
  - Write: we_n=0, data still driven.
  - On the edge ending the last STROBE cycle, a read captures ram_data into the granted port's rdata register.
- HOLD (1 cycle):
  - oe_n=we_n=1; ce_n=0; addr and write data still driven.
  - The granted port's ack=1.
  - Next state is IDLE.
- Latency:
  - Request sampled at edge t0 → ack high during cycle t0+WAIT_CYC+2 (t0+4 at default).
  - A back-to-back access starts with its IDLE sample one cycle after the ack cycle.
  - Throughput is one access per WAIT_CYC+3 cycles.
- Ack timing: a requester still asserting in the IDLE cycle after its ack is taken as a new request.
- Persistence: rdata registers hold their value until the next read for that same port. Writes never modify rdata.
- busy = (state != IDLE).
- ram_addr holds its last value in IDLE, and ce_n=1 there.

Test Plan:
- Single IF read at addr 0x00010; SRAM model returns 0xBEEF → if_ack pulses exactly 4 cycles after the sample edge; if_rdata=0xBEEF; oe_n low 2 cycles; we_n stays 1; mem_ack stays 0.
- MEM write addr 0x3FFFF, data 0x1234 → we_n low 2 cycles; ram_data=0x1234 from SETUP through HOLD, else Z; mem_ack one pulse; read-back via MEM read returns 0x1234; mem_rdata unchanged by the write.
- if_req and mem_rd asserted together out of reset, both held → MEM granted first, then IF, then MEM; acks alternate; each access spans 5 cycles.
- Assert rst during the STROBE of a write → next edge: we_n=ce_n=1, ram_data=Z, busy=0; no mem_ack ever pulses; SRAM model shows the write incomplete or ignored.
- WAIT_CYC=1 and WAIT_CYC=15 builds, IF read → ack at t0+3 and t0+17 respectively; oe_n low for exactly WAIT_CYC cycles.
- mem_rd=mem_wr=1 with data 0x00FF → executes a write; ram_oe_n never low.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester SRAM port arbiter with setup/strobe/hold sequencing
//
// Shares one asynchronous SRAM port between the instruction-fetch (IF) and the
// data-memory (MEM) requesters. Each access runs IDLE -> SETUP -> STROBE x WAIT_CYC
// -> HOLD, and the granted requester gets a one-cycle ack during HOLD.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   if_req/if_addr             IF read request (level, held until if_ack)
//   if_ack/if_rdata            IF completion pulse and last word read for IF
//   mem_rd/mem_wr/mem_addr     MEM request (level, held until mem_ack); rd+wr = write
//   mem_wdata                  MEM write data
//   mem_ack/mem_rdata          MEM completion pulse and last word read for MEM
//   busy                       high whenever an access is in progress
//   ram_addr/ram_data          SRAM address and bidirectional data bus
//   ram_ce_n/ram_oe_n/ram_we_n SRAM strobes, active low
module mem_arbiter #(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 16,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  // Grant encoding: 0 = IF, 1 = MEM.
  localparam logic GRANT_IF  = 1'b0;
  localparam logic GRANT_MEM = 1'b1;
  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYC - 1);

  state_t            state, state_nx;
  logic              last_grant;
  logic              grant_q;
  logic              op_wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        cnt_q;

  logic mem_req;
  logic any_req;
  logic grant_sel;
  logic strobe_last;
  logic drive_data;

  assign mem_req     = mem_rd | mem_wr;
  assign any_req     = if_req | mem_req;
  assign strobe_last = (state == STROBE) && (cnt_q == CNT_LAST);

  // Round-robin only matters on a tie: the side that did not win last time goes.
  always_comb begin
    grant_sel = GRANT_IF;
    if (if_req && mem_req) grant_sel = ~last_grant;
    else if (mem_req)      grant_sel = GRANT_MEM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_IF;
      grant_q    <= GRANT_IF;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
    end else begin
      state <= state_nx;
      // Requester inputs are only looked at here; they are don't-care until the ack.
      if (state == IDLE && any_req) begin
        grant_q    <= grant_sel;
        last_grant <= grant_sel;
        op_wr_q    <= (grant_sel == GRANT_MEM) && mem_wr;
        addr_q     <= (grant_sel == GRANT_MEM) ? mem_addr : if_addr;
        wdata_q    <= mem_wdata;
      end
      if (state == SETUP)       cnt_q <= '0;
      else if (state == STROBE) cnt_q <= cnt_q + 4'd1;
      // Read data is taken on the edge that ends the final strobe cycle.
      if (strobe_last && !op_wr_q) begin
        if (grant_q == GRANT_MEM) mem_rdata <= ram_data;
        else                      if_rdata  <= ram_data;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    busy       = 1'b1;
    ram_ce_n   = 1'b0;
    ram_oe_n   = 1'b1;
    ram_we_n   = 1'b1;
    if_ack     = 1'b0;
    mem_ack    = 1'b0;
    drive_data = op_wr_q;
    case (state)
      IDLE: begin
        busy       = 1'b0;
        ram_ce_n   = 1'b1;
        drive_data = 1'b0;
        if (any_req) state_nx = SETUP;
      end
      SETUP: state_nx = STROBE;
      STROBE: begin
        ram_oe_n = op_wr_q;
        ram_we_n = ~op_wr_q;
        if (strobe_last) state_nx = HOLD;
      end
      HOLD: begin
        if_ack   = (grant_q == GRANT_IF);
        mem_ack  = (grant_q == GRANT_MEM);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign ram_addr = addr_q;
  assign ram_data = drive_data ? wdata_q : {DATA_W{1'bz}};

endmodule
